// File: rtl/lynxTypes.sv
// Shared constants and types for the read-response completion tracker.
package lynxTypes;

  localparam int BEAT_BYTES    = 64;
  localparam int BEAT_SHIFT    = $clog2(BEAT_BYTES);
  localparam int CMPL_TID_BITS = 6;

  typedef struct packed {
    logic [CMPL_TID_BITS-1:0] tid;
    logic                     err;
  } cmpl_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_HOLD   = 2'd2
  } trk_state_e;

endpackage

// File: rtl/rd_cmpl_fifo.sv
// Issue FIFO holding {tid, beats} per outstanding read; pointers carry an extra wrap bit.
module rd_cmpl_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 29
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge aclk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rd_resp_cmpl_tracker.sv
// Matches read-response beats to issued requests and emits one completion per packet.
module rd_resp_cmpl_tracker
  import lynxTypes::*;
#(
  parameter int QDEPTH    = 16,
  parameter int LEN_BITS  = 28,
  parameter int TID_BITS  = 6,
  parameter int DATA_BITS = 512
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_issue_valid,
  output logic                     s_issue_ready,
  input  logic [LEN_BITS-1:0]      s_issue_len,
  input  logic [TID_BITS-1:0]      s_issue_tid,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [DATA_BITS-1:0]     s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]   s_axis_tkeep,
  input  logic [TID_BITS-1:0]      s_axis_tid,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [DATA_BITS-1:0]     m_axis_tdata,
  output logic [DATA_BITS/8-1:0]   m_axis_tkeep,
  output logic [TID_BITS-1:0]      m_axis_tid,
  output logic                     m_cmpl_valid,
  input  logic                     m_cmpl_ready,
  output logic [TID_BITS-1:0]      m_cmpl_tid,
  output logic                     m_cmpl_err,
  output logic [$clog2(QDEPTH):0]  outstanding,
  output logic                     err_sticky
);

  localparam int CNT_BITS = LEN_BITS - 5;
  localparam int ENT_BITS = TID_BITS + CNT_BITS;
  localparam int CW       = $clog2(QDEPTH) + 1;

  trk_state_e          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  cmpl_t               cmpl_q, cmpl_d;
  logic                cmpl_valid_q, cmpl_valid_d;
  logic                err_sticky_q, err_sticky_d;

  logic                issue_push;
  logic [LEN_BITS:0]   len_round;
  logic [CNT_BITS-1:0] issue_beats;
  logic [ENT_BITS-1:0] head_data;
  logic [TID_BITS-1:0] head_tid;
  logic [CNT_BITS-1:0] head_beats;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]       fifo_count;
  logic                more_after_pop;
  logic                beat_ok, beat_fire;

  assign s_issue_ready = aresetn && !fifo_full;
  assign issue_push    = s_issue_valid && s_issue_ready;
  assign len_round     = {1'b0, s_issue_len} + (LEN_BITS+1)'(BEAT_BYTES - 1);
  assign issue_beats   = (s_issue_len == '0) ? CNT_BITS'(1) : CNT_BITS'(len_round >> BEAT_SHIFT);

  rd_cmpl_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ENT_BITS)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (issue_push),
    .push_data ({s_issue_tid, issue_beats}),
    .pop       (fifo_pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_tid       = head_data[ENT_BITS-1:CNT_BITS];
  assign head_beats     = head_data[CNT_BITS-1:0];
  assign more_after_pop = (fifo_count > CW'(1)) || issue_push;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tid    = s_axis_tid;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_cmpl_valid  = cmpl_valid_q;
  assign m_cmpl_tid    = TID_BITS'(cmpl_q.tid);
  assign m_cmpl_err    = cmpl_q.err;
  assign outstanding   = fifo_count;
  assign err_sticky    = err_sticky_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmpl_d        = cmpl_q;
    cmpl_valid_d  = cmpl_valid_q;
    err_sticky_d  = err_sticky_q;
    m_axis_tvalid = 1'b0;
    s_axis_tready = 1'b0;
    fifo_pop      = 1'b0;
    beat_ok       = 1'b0;
    beat_fire     = 1'b0;

    if (cmpl_valid_q && m_cmpl_ready) cmpl_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // A closing beat waits while an older completion is still unaccepted.
        beat_ok       = !s_axis_tlast || !cmpl_valid_q || m_cmpl_ready;
        m_axis_tvalid = s_axis_tvalid && beat_ok;
        s_axis_tready = m_axis_tready && beat_ok;
        beat_fire     = s_axis_tvalid && m_axis_tready && beat_ok;
        if (beat_fire) begin
          if (s_axis_tlast) begin
            fifo_pop     = 1'b1;
            cnt_d        = '0;
            cmpl_d.tid   = CMPL_TID_BITS'(head_tid);
            cmpl_d.err   = (({1'b0, cnt_q} + (CNT_BITS+1)'(1)) != {1'b0, head_beats}) ||
                           (s_axis_tid != head_tid);
            cmpl_valid_d = 1'b1;
            if (cmpl_d.err) err_sticky_d = 1'b1;
            if (!m_cmpl_ready)       state_d = ST_HOLD;
            else if (more_after_pop) state_d = ST_STREAM;
            else                     state_d = ST_IDLE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
      end
      ST_HOLD: begin
        if (m_cmpl_ready) state_d = fifo_empty ? ST_IDLE : ST_STREAM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cmpl_q       <= '0;
      cmpl_valid_q <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmpl_q       <= cmpl_d;
      cmpl_valid_q <= cmpl_valid_d;
      err_sticky_q <= err_sticky_d;
    end
  end

endmodule
